regs_sb: RTL
============

// Module: regs_sb
// PURPOSE
//  Parametrised integer register file for the 5-stage pipe with N read ports, one WB write port,
//  same-cycle write-to-read bypass and a per-register busy scoreboard. ID marks rd busy at issue;
//  WB clears the bit on write. ID uses rbusy_o to generate RAW stalls.
//  Successor to the fixed 2-read, 32x32 file.
// PARAMETERS
//  XLEN     32  data width
//  AW       5   address width; DEPTH = 2**AW
//  NRD      2   number of read ports
//  ZERO_REG 1   1: x0 reads 0; writes/issues to x0 ignored
//  BYPASS   1   1: WB write data forwarded combinationally to same-cycle reads
// PORTS
//  clk_100MHz  in   1          clock, rising edge
//  arst_n      in   1          async reset, active low
//  raddr_i     in   NRD*AW     read addresses, port k at [k*AW +: AW]
//  rdata_o     out  NRD*XLEN   read data, port k at [k*XLEN +: XLEN], combinational
//  rbusy_o     out  NRD        port k's register has a pending producer
//  wb_we_i     in   1          WB write enable
//  wb_waddr_i  in   AW         WB write address
//  wb_wdata_i  in   XLEN       WB write data
//  id_issue_i  in   1          ID issues an instruction that writes id_rd_i
//  id_rd_i     in   AW         destination of the issued instruction
//  flush_i     in   1          pipeline flush: clear all busy bits
//  busy_cnt_o  out  AW+1       registered count of set busy bits
// BEHAVIOUR
//  Reset (arst_n=0, async)
//   - All DEPTH regs = 0, all busy bits = 0, busy_cnt_o = 0.
//   - Outputs follow at once: rdata_o = 0, rbusy_o = 0.
//   - Reset mid-operation drops pending writes and issues.
//  Write (sync)
//   - On posedge, if wb_we_i and not (ZERO_REG and wb_waddr_i==0): mem[wb_waddr_i] <= wb_wdata_i.
//   - Written whether or not the register is busy. flush_i does not block writes.
//  Read (comb, 0 latency)
//   - rdata_k = 0 if ZERO_REG and raddr_k==0.
//   - Else wb_wdata_i if BYPASS and wb_we_i and wb_waddr_i==raddr_k.
//   - Else mem[raddr_k].
//   - BYPASS=0: new data is visible the cycle after the write.
//  Scoreboard busy[i] (sync), per posedge
//   - If flush_i: busy <= 0. A same-cycle issue is discarded.
//   - Else:
//     - WB clear: wb_we_i clears busy[wb_waddr_i].
//     - Issue set: id_issue_i sets busy[id_rd_i].
//     - Issue and WB to the same reg in one cycle: issue wins, bit stays 1 (newer producer).
//     - Repeated issue to an already busy reg: stays 1, count unchanged.
//     - WB to a non-busy reg: bit stays 0.
//   - Index 0 never set when ZERO_REG=1.
//  rbusy_k (comb)
//   - 0 if ZERO_REG and raddr_k==0.
//   - Else busy[raddr_k] & ~(BYPASS & wb_we_i & wb_waddr_i==raddr_k).
//   - The same-cycle WB resolves the hazard via bypass.
//  busy_cnt_o
//   - Equals popcount(busy) after every edge.
//   - Updated incrementally by +1/0/-1 per cycle. Flush sets it to 0.
//   - Max DEPTH (or DEPTH-1 with ZERO_REG=1); never wraps.
//  Read address: any value in 0..DEPTH-1; multiple ports may read the same address.
// TESTING
//  1. Reset: pulse arst_n low mid-cycle -> rdata_o=0, rbusy_o=0, busy_cnt_o=0 immediately.
//  2. Write x5=0xDEADBEEF; next cycle read x5 on both ports -> 0xDEADBEEF.
//     Write x0=0x1 -> x0 reads 0.
//  3. Bypass: wb_we_i=1, waddr=7, wdata=0x1234, raddr0=7 same cycle -> rdata0=0x1234.
//     With BYPASS=0 -> old value.
//  4. Scoreboard: issue rd=3 -> next cycle rbusy=1 on port reading x3, busy_cnt=1.
//     WB x3 -> rbusy=0 that cycle (bypass), busy_cnt=0 after edge.
//  5. Same-cycle issue rd=4 and WB x4 with x4 busy -> busy[4] stays 1, busy_cnt unchanged.
//     Issue rd=0 -> no change.
//  6. Issue x1..x31 -> busy_cnt=31. flush_i with issue rd=9 -> all busy 0, busy_cnt=0.
//     Register data retained.

Source files
------------

// File: rtl/regs_sb_if.sv
// Register-file bus: read ports, WB write port, ID issue, flush and busy count.
// Drivers use the master modport; regs_sb uses the slave modport.
interface regs_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rbusy_o;
  logic                wb_we_i;
  logic [AW-1:0]       wb_waddr_i;
  logic [XLEN-1:0]     wb_wdata_i;
  logic                id_issue_i;
  logic [AW-1:0]       id_rd_i;
  logic                flush_i;
  logic [AW:0]         busy_cnt_o;

  modport master (
    output raddr_i, wb_we_i, wb_waddr_i, wb_wdata_i, id_issue_i, id_rd_i, flush_i,
    input  rdata_o, rbusy_o, busy_cnt_o
  );

  modport slave (
    input  raddr_i, wb_we_i, wb_waddr_i, wb_wdata_i, id_issue_i, id_rd_i, flush_i,
    output rdata_o, rbusy_o, busy_cnt_o
  );
endinterface

// File: rtl/regs_sb.sv
// Integer register file with NRD combinational read ports, one WB write port,
// same-cycle WB bypass and a per-register busy scoreboard with a running count.
module regs_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic       clk_100MHz,
  input logic       arst_n,
  regs_sb_if.slave  bus
);

  localparam int unsigned Depth = 2 ** AW;

  logic [XLEN-1:0] mem_q [Depth];
  logic [XLEN-1:0] mem_d [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_en, iss_en, inc, dec;

  always_comb begin
    wr_en  = bus.wb_we_i && !((ZERO_REG != 0) && (bus.wb_waddr_i == '0));
    iss_en = bus.id_issue_i && !((ZERO_REG != 0) && (bus.id_rd_i == '0));

    mem_d = mem_q;
    if (wr_en) mem_d[bus.wb_waddr_i] = bus.wb_wdata_i;

    busy_d = busy_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (bus.flush_i) begin
      busy_d = '0;
    end else begin
      if (bus.wb_we_i) busy_d[bus.wb_waddr_i] = 1'b0;
      // Issue is applied after the WB clear so a newer producer keeps the bit set.
      if (iss_en) busy_d[bus.id_rd_i] = 1'b1;
      inc = iss_en && !busy_q[bus.id_rd_i];
      dec = bus.wb_we_i && busy_q[bus.wb_waddr_i] &&
            !(iss_en && (bus.id_rd_i == bus.wb_waddr_i));
    end

    if (bus.flush_i) cnt_d = '0;
    else             cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp, zero;

    always_comb begin
      ra   = bus.raddr_i[k*AW +: AW];
      byp  = (BYPASS != 0) && bus.wb_we_i && (bus.wb_waddr_i == ra);
      zero = (ZERO_REG != 0) && (ra == '0);
    end

    assign bus.rdata_o[k*XLEN +: XLEN] = zero ? '0 : (byp ? bus.wb_wdata_i : mem_q[ra]);
    // A same-cycle WB to this register resolves the hazard through the bypass.
    assign bus.rbusy_o[k] = !zero && busy_q[ra] && !byp;
  end

  assign bus.busy_cnt_o = cnt_q;

endmodule
